// File: rtl/gfx_pkg.sv
// Shared graphics definitions: canvas config field widths, the packed {y, x}
// coordinate layout and the pixel order within a VRAM word.
package gfx_pkg;

  localparam int GFX_CORDW  = 16;  // signed coordinate width
  localparam int GFX_WORD   = 32;  // VRAM word width
  localparam int GFX_ADDRW  = 18;  // VRAM word address width
  localparam int GFX_COLRW  = 8;   // colour width
  localparam int GFX_SHIFTW = 3;   // log2(pixels per word) field width

  // Packed coordinate pair as used by window start and scale registers.
  typedef struct packed {
    logic signed [GFX_CORDW-1:0] y;
    logic signed [GFX_CORDW-1:0] x;
  } coord_t;

  // Pixel 0 of a word sits in the least significant bits.
  localparam bit PIX_LSB_FIRST = 1'b1;

endpackage

// File: rtl/canv_draw_agu_if.sv
// Pixel request / VRAM write handshake bundle for the canvas draw AGU.
// slave: the AGU side; master: drawing engine + VRAM arbiter side.
interface canv_draw_agu_if #(
  parameter int CORDW   = gfx_pkg::GFX_CORDW,
  parameter int WORD    = gfx_pkg::GFX_WORD,
  parameter int ADDRW   = gfx_pkg::GFX_ADDRW,
  parameter int COLRW   = gfx_pkg::GFX_COLRW,
  parameter int PIX_IDW = $clog2(WORD)
);

  logic               in_valid;
  logic               in_ready;
  logic [CORDW-1:0]   in_x;
  logic [CORDW-1:0]   in_y;
  logic [COLRW-1:0]   in_colr;

  logic               out_valid;
  logic               out_ready;
  logic [ADDRW-1:0]   out_addr;
  logic [WORD-1:0]    out_data;
  logic [WORD-1:0]    out_mask;
  logic [PIX_IDW-1:0] out_pix_id;

  modport slave (
    input  in_valid, in_x, in_y, in_colr, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_mask, out_pix_id
  );

  modport master (
    output in_valid, in_x, in_y, in_colr, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_mask, out_pix_id
  );

endinterface

// File: rtl/canv_pix_place.sv
// Places one colour into its pixel slot of a VRAM word and builds the matching
// bit write mask. Purely combinational; shift must already be clamped.
module canv_pix_place import gfx_pkg::*; #(
  parameter int WORD    = GFX_WORD,
  parameter int COLRW   = GFX_COLRW,
  parameter int SHIFTW  = GFX_SHIFTW,
  parameter int PIX_IDW = $clog2(WORD)
) (
  input  logic [COLRW-1:0]   i_colr,
  input  logic [PIX_IDW-1:0] i_pix_id,
  input  logic [SHIFTW-1:0]  i_shift,
  output logic [WORD-1:0]    o_data,
  output logic [WORD-1:0]    o_mask
);

  // bpp can equal WORD (shift 0), hence one extra bit
  localparam int BPPW = PIX_IDW + 1;

  logic [BPPW-1:0]    w_bpp;
  logic [WORD-1:0]    w_slot_mask;
  logic [WORD-1:0]    w_colr_fit;
  logic [PIX_IDW-1:0] w_slot;
  logic [PIX_IDW-1:0] w_off;

  assign w_bpp = BPPW'(WORD >> i_shift);
  // 1 << WORD wraps to zero, so the subtraction yields all ones for full-word pixels
  assign w_slot_mask = (WORD'(1) << w_bpp) - WORD'(1);
  assign w_colr_fit  = WORD'(i_colr) & w_slot_mask;

  generate
    if (PIX_LSB_FIRST) begin : g_lsb_first
      assign w_slot = i_pix_id;
    end else begin : g_msb_first
      assign w_slot = PIX_IDW'((1 << i_shift) - 1) - i_pix_id;
    end
  endgenerate

  assign w_off  = PIX_IDW'(w_slot * w_bpp);
  assign o_data = w_colr_fit << w_off;
  assign o_mask = w_slot_mask << w_off;

endmodule

// File: rtl/canv_draw_agu.sv
// Canvas draw AGU: turns (x, y, colour) pixel writes into VRAM word writes
// (address, positioned data, bit mask) using the display path's base/shift
// packing. Three-stage pipeline with a single global advance.
// Optional build macro CANV_DRAW_AGU_TRANS_EN: pixels whose colour equals
// trans_colr are dropped like clipped pixels.
module canv_draw_agu import gfx_pkg::*; #(
  parameter int CORDW   = GFX_CORDW,
  parameter int WORD    = GFX_WORD,
  parameter int ADDRW   = GFX_ADDRW,
  parameter int COLRW   = GFX_COLRW,
  parameter int SHIFTW  = GFX_SHIFTW,
  parameter int PIX_IDW = $clog2(WORD)
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic [ADDRW-1:0]  addr_base,
  input  logic [SHIFTW-1:0] addr_shift,
  input  logic [CORDW-1:0]  canv_w,
  input  logic [CORDW-1:0]  canv_h,
  input  logic [COLRW-1:0]  trans_colr,
  canv_draw_agu_if.slave    bus,
  output logic              busy
);

  localparam int LINW  = ADDRW + PIX_IDW;
  localparam int MULW  = (LINW > 2*CORDW) ? LINW : 2*CORDW;
  localparam int LOG2W = $clog2(WORD);

  logic               w_adv;
  logic               w_clip;
  logic               w_drop;
  logic signed [CORDW:0] w_x_ext, w_y_ext, w_w_ext, w_h_ext;
  logic [SHIFTW-1:0]  w_shift;
  logic [PIX_IDW-1:0] w_pid_mask, w_pix_id;
  logic [WORD-1:0]    w_data, w_mask;

  logic               r_s1_valid;
  logic [CORDW-1:0]   r_s1_x, r_s1_y;
  logic [COLRW-1:0]   r_s1_colr;
  logic               r_s2_valid;
  logic [LINW-1:0]    r_s2_lin;
  logic [COLRW-1:0]   r_s2_colr;
  logic               r_out_valid;
  logic [ADDRW-1:0]   r_out_addr;
  logic [WORD-1:0]    r_out_data, r_out_mask;
  logic [PIX_IDW-1:0] r_out_pix_id;

  // Everything moves together unless the output word is waiting
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Signed coordinates against zero-extended canvas dimensions
  assign w_x_ext = {bus.in_x[CORDW-1], bus.in_x};
  assign w_y_ext = {bus.in_y[CORDW-1], bus.in_y};
  assign w_w_ext = {1'b0, canv_w};
  assign w_h_ext = {1'b0, canv_h};
  assign w_clip  = bus.in_x[CORDW-1] || bus.in_y[CORDW-1] ||
                   (w_x_ext >= w_w_ext) || (w_y_ext >= w_h_ext);

`ifdef CANV_DRAW_AGU_TRANS_EN
  assign w_drop = w_clip || (bus.in_colr == trans_colr);
`else
  logic w_unused_trans;
  assign w_unused_trans = ^trans_colr;
  assign w_drop = w_clip;
`endif

  // Oversized shifts fall back to 1 bpp
  assign w_shift    = (addr_shift > SHIFTW'(LOG2W)) ? SHIFTW'(LOG2W) : addr_shift;
  assign w_pid_mask = PIX_IDW'((1 << w_shift) - 1);
  assign w_pix_id   = r_s2_lin[PIX_IDW-1:0] & w_pid_mask;

  canv_pix_place #(
    .WORD(WORD), .COLRW(COLRW), .SHIFTW(SHIFTW), .PIX_IDW(PIX_IDW)
  ) u_place (
    .i_colr(r_s2_colr), .i_pix_id(w_pix_id), .i_shift(w_shift),
    .o_data(w_data), .o_mask(w_mask)
  );

  // S1: accept request; clipped or keyed pixels enter as bubbles
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_colr  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid && !w_drop;
      r_s1_x     <= bus.in_x;
      r_s1_y     <= bus.in_y;
      r_s1_colr  <= bus.in_colr;
    end
  end

  // S2: linear pixel index, coordinates known non-negative here
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_s2_valid <= 1'b0;
      r_s2_lin   <= '0;
      r_s2_colr  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_lin   <= LINW'(MULW'(r_s1_y) * MULW'(canv_w) + MULW'(r_s1_x));
      r_s2_colr  <= r_s1_colr;
    end
  end

  // S3: word address, slot data and mask
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_out_mask   <= '0;
      r_out_pix_id <= '0;
    end else if (w_adv) begin
      r_out_valid  <= r_s2_valid;
      r_out_addr   <= addr_base + ADDRW'(r_s2_lin >> w_shift);
      r_out_data   <= w_data;
      r_out_mask   <= w_mask;
      r_out_pix_id <= w_pix_id;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_addr   = r_out_addr;
  assign bus.out_data   = r_out_data;
  assign bus.out_mask   = r_out_mask;
  assign bus.out_pix_id = r_out_pix_id;
  assign busy           = r_s1_valid | r_s2_valid | r_out_valid;

endmodule

// File: tb/tb_canv_draw_agu.sv
// Directed bench for canv_draw_agu (default parameters).
module tb_canv_draw_agu;
  import gfx_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic [17:0] addr_base;
  logic [2:0]  addr_shift;
  logic [15:0] canv_w, canv_h;
  logic [7:0]  trans_colr;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  canv_draw_agu_if bus ();

  canv_draw_agu dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .addr_base(addr_base),
    .addr_shift(addr_shift), .canv_w(canv_w), .canv_h(canv_h),
    .trans_colr(trans_colr), .bus(bus), .busy(busy)
  );

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
    logic [4:0]  pid;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // Record every completed VRAM write
  always @(negedge clk_sys) begin
    if (rst_sys_n && bus.out_valid && bus.out_ready) begin
      q.push_back({bus.out_addr, bus.out_data, bus.out_mask, bus.out_pix_id});
      $display("wr addr=%h data=%h mask=%h pid=%0d", bus.out_addr, bus.out_data,
               bus.out_mask, bus.out_pix_id);
    end
  end

  task automatic send(input int x, input int y, input logic [7:0] c, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'(x);
    bus.in_y     = 16'(y);
    bus.in_colr  = c;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk_sys); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic measure_latency(output int lat);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_sys);
      if (bus.out_valid) begin lat = i; break; end
    end
  endtask

  task automatic wait_idle(output bit done);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      if (!busy) begin done = 1'b1; break; end
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic config_canvas(input logic [17:0] base, input logic [2:0] sh);
    addr_base = base; addr_shift = sh; canv_w = 16'd320; canv_h = 16'd240;
  endtask

  task automatic test_reset;
    rst_sys_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_colr = '0;
    bus.out_ready = 1'b1; trans_colr = 8'h00;
    config_canvas(18'h100, 3'd2);
    repeat (2) @(posedge clk_sys);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_addr !== 18'h0) $display("FAIL reset_out_addr: got %h expected 0", bus.out_addr); else n_pass++;
    n_checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data: got %h expected 0", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_mask !== 32'h0) $display("FAIL reset_out_mask: got %h expected 0", bus.out_mask); else n_pass++;
    n_checks++; if (bus.out_pix_id !== 5'd0) $display("FAIL reset_pix_id: got %0d expected 0", bus.out_pix_id); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    @(negedge clk_sys); rst_sys_n = 1'b1;
    @(posedge clk_sys); #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_base_write;
    bit ok, done; int lat;
    config_canvas(18'h100, 3'd2);
    q.delete();
    send(5, 2, 8'hAB, ok);
    measure_latency(lat);
    n_checks++; if (lat !== 3) $display("FAIL base_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (bus.out_addr !== 18'h1A1) $display("FAIL base_addr: got %h expected 1a1", bus.out_addr); else n_pass++;
    n_checks++; if (bus.out_data !== 32'h0000AB00) $display("FAIL base_data: got %h expected 0000ab00", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_mask !== 32'h0000FF00) $display("FAIL base_mask: got %h expected 0000ff00", bus.out_mask); else n_pass++;
    n_checks++; if (bus.out_pix_id !== 5'd1) $display("FAIL base_pix_id: got %0d expected 1", bus.out_pix_id); else n_pass++;
    wait_idle(done);
    n_checks++; if (!(ok && done && q.size() == 1)) $display("FAIL base_count: got accepted=%0d idle=%0d writes=%0d expected 1 1 1", ok, done, q.size()); else n_pass++;
  endtask

  // 1 bpp, clamped oversize shift, and full-word 32 bpp
  task automatic test_shift_edges;
    logic [2:0]  sh[3]  = '{3'd5, 3'd7, 3'd0};
    int          xs[3]  = '{33, 33, 3};
    int          ys[3]  = '{0, 0, 1};
    logic [7:0]  cs[3]  = '{8'hFF, 8'h01, 8'hAB};
    logic [17:0] ea[3]  = '{18'h101, 18'h101, 18'h243};
    logic [31:0] ed[3]  = '{32'h2, 32'h2, 32'hAB};
    logic [31:0] em[3]  = '{32'h2, 32'h2, 32'hFFFFFFFF};
    logic [4:0]  ep[3]  = '{5'd1, 5'd1, 5'd0};
    bit ok, done;
    for (int k = 0; k < 3; k++) begin
      config_canvas(18'h100, sh[k]);
      q.delete();
      send(xs[k], ys[k], cs[k], ok);
      wait_idle(done);
      n_checks++;
      if (!(ok && done && q.size() == 1)) $display("FAIL shift%0d_count: got writes=%0d expected 1", k, q.size());
      else begin
        n_pass++;
        n_checks++; if (q[0] !== {ea[k], ed[k], em[k], ep[k]})
          $display("FAIL shift%0d_write: got addr=%h data=%h mask=%h pid=%0d expected addr=%h data=%h mask=%h pid=%0d",
                   k, q[0].addr, q[0].data, q[0].mask, q[0].pid, ea[k], ed[k], em[k], ep[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clip;
    int xs[4] = '{-1, 320, 0, 319};
    int ys[4] = '{0, 0, 240, 239};
    bit ok, done; int acc = 0;
    config_canvas(18'h100, 3'd2);
    q.delete();
    for (int k = 0; k < 4; k++) begin
      send(xs[k], ys[k], 8'(8'h11 * (k + 1)) | 8'h48, ok);
      if (ok) acc++;
    end
    wait_idle(done);
    n_checks++; if (acc !== 4) $display("FAIL clip_accepts: got %0d expected 4", acc); else n_pass++;
    n_checks++;
    if (!(done && q.size() == 1)) $display("FAIL clip_count: got writes=%0d expected 1", q.size());
    else begin
      n_pass++;
      // last colour: 0x44 | 0x48 = 0x4C at slot 3
      n_checks++; if (q[0] !== {18'h4BFF, 32'h4C000000, 32'hFF000000, 5'd3})
        $display("FAIL clip_write: got addr=%h data=%h mask=%h pid=%0d expected addr=4bff data=4c000000 mask=ff000000 pid=3",
                 q[0].addr, q[0].data, q[0].mask, q[0].pid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, stalls = 0;
    wr_t snap = '0;
    bit done;
    config_canvas(18'h000, 3'd2);
    q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk_sys); #1;
      bus.out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) begin
        bus.in_valid = 1'b1; bus.in_x = 16'(sent); bus.in_y = 16'd0; bus.in_colr = 8'(16 + sent);
      end else bus.in_valid = 1'b0;
      @(negedge clk_sys);
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && !bus.out_ready) begin
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
        if (stalls > 0) begin
          n_checks++;
          if ({bus.out_addr, bus.out_data, bus.out_mask, bus.out_pix_id} !== snap)
            $display("FAIL stall_hold: got addr=%h data=%h expected addr=%h data=%h", bus.out_addr, bus.out_data, snap.addr, snap.data);
          else n_pass++;
        end else snap = {bus.out_addr, bus.out_data, bus.out_mask, bus.out_pix_id};
        stalls++;
      end
    end
    @(posedge clk_sys); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    wait_idle(done);
    n_checks++; if (stalls !== 5) $display("FAIL stall_cycles: got %0d expected 5", stalls); else n_pass++;
    n_checks++;
    if (!(done && sent == 8 && q.size() == 8)) $display("FAIL burst_count: got sent=%0d writes=%0d expected 8 8", sent, q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (q[i] !== {18'(i / 4), 32'(16 + i) << (8 * (i % 4)), 32'hFF << (8 * (i % 4)), 5'(i % 4)})
          $display("FAIL burst_write%0d: got addr=%h data=%h mask=%h pid=%0d", i, q[i].addr, q[i].data, q[i].mask, q[i].pid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset;
    bit ok, done; int lat;
    config_canvas(18'h100, 3'd2);
    bus.out_ready = 1'b1;
    q.delete();
    send(10, 0, 8'h01, ok);
    send(11, 0, 8'h02, ok);
    send(12, 0, 8'h03, ok);
    #2 rst_sys_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else n_pass++;
    @(negedge clk_sys); rst_sys_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    n_checks++; if (busy !== 1'b0 || q.size() != 0) $display("FAIL arst_dropped: got busy=%b writes=%0d expected 0 0", busy, q.size()); else n_pass++;
    send(5, 2, 8'hAB, ok);
    measure_latency(lat);
    n_checks++; if (lat !== 3) $display("FAIL arst_latency: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (bus.out_addr !== 18'h1A1) $display("FAIL arst_addr: got %h expected 1a1", bus.out_addr); else n_pass++;
    wait_idle(done);
    n_checks++; if (!(done && q.size() == 1)) $display("FAIL arst_count: got writes=%0d expected 1", q.size()); else n_pass++;
  endtask

  task automatic test_trans;
    bit ok, done; int exp_n;
`ifdef CANV_DRAW_AGU_TRANS_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    config_canvas(18'h000, 3'd2);
    trans_colr = 8'h00;
    q.delete();
    send(1, 0, 8'h00, ok);
    send(2, 0, 8'h11, ok);
    wait_idle(done);
    n_checks++;
    if (!(done && q.size() == exp_n)) $display("FAIL trans_count: got %0d expected %0d", q.size(), exp_n);
    else begin
      n_pass++;
      n_checks++; if (q[exp_n-1] !== {18'h0, 32'h00110000, 32'h00FF0000, 5'd2})
        $display("FAIL trans_write: got addr=%h data=%h mask=%h pid=%0d expected addr=0 data=00110000 mask=00ff0000 pid=2",
                 q[exp_n-1].addr, q[exp_n-1].data, q[exp_n-1].mask, q[exp_n-1].pid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_base_write();
    test_shift_edges();
    test_clip();
    test_back_to_back();
    test_async_reset();
    test_trans();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/canv_draw_agu.md
Name: canv_draw_agu

Overview:
- Write-side counterpart of the canvas display AGU.
- Turns drawing-engine pixel writes (x, y, colour) into VRAM word writes: word address, positioned data and bit write mask.
- Uses the same canvas base/shift packing as the display path, so drawn pixels appear where the display AGU reads them.
- Sits between the 2D drawing engine and the VRAM write port arbiter in the system clock domain.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- WORD, 32, machine/VRAM word size (bits)
- ADDRW, 18, VRAM word address width (bits)
- COLRW, 8, input colour width (bits)
- SHIFTW, 3, address shift width (bits); log2 of pixels per word
- PIX_IDW, $clog2(WORD), pixel ID width (bits)

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  reset, asynchronous, active-low
- addr_base  in  ADDRW  canvas base word address
- addr_shift  in  SHIFTW  log2(pixels per word); bpp = WORD >> addr_shift
- canv_w  in  CORDW  canvas width (pixels, unsigned)
- canv_h  in  CORDW  canvas height (pixels, unsigned)
- trans_colr  in  COLRW  transparent colour key (optional feature)
- in_valid  in  1  pixel request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_x  in  CORDW  signed pixel x
- in_y  in  CORDW  signed pixel y
- in_colr  in  COLRW  pixel colour
- out_valid  out  1  VRAM write valid
- out_ready  in  1  VRAM write accepted
- out_addr  out  ADDRW  VRAM word address
- out_data  out  WORD  colour placed at pixel slot, zeros elsewhere
- out_mask  out  WORD  bit write mask, ones over pixel slot only
- out_pix_id  out  PIX_IDW  pixel index within word
- busy  out  1  any pipeline stage holds a valid pixel

Behaviour:
- Reset: out_valid=0, out_addr=0, out_data=0, out_mask=0, out_pix_id=0, busy=0, all stage valids cleared. Async assert, sync-safe deassert.
- Three-stage pipeline, one global advance: adv = !out_valid || out_ready; in_ready = adv.
- Unstalled latency: 3 cycles from accept to out_valid. Throughput: 1 pixel/cycle.
- S1 (accept):
  - Register x, y, colour.
  - clip = (x<0) || (y<0) || (x>=canv_w) || (y>=canv_h); compares are signed against zero-extended canvas dims.
  - s1_valid = accepted && !clip.
- S2: lin = y*canv_w + x, unsigned, width ADDRW+PIX_IDW, truncated.
- S3 (output):
  - out_addr = addr_base + (lin >> addr_shift), modulo 2^ADDRW.
  - pix_id = lin & ((1<<addr_shift)-1).
  - colour zero-extended or truncated to bpp, then placed at bits [pix_id*bpp +: bpp].
  - Pixel 0 occupies the LSBs (same order the display AGU reads).
- Clipped requests are accepted (in_ready unaffected) and become bubbles; never written.
- Stall: while out_valid && !out_ready, every stage holds its contents and out_* stay stable.
- Config ports (addr_base, addr_shift, canv_w, canv_h) are sampled at the stage using them. They may change only when busy=0; otherwise behaviour is undefined.
- addr_shift > log2(WORD) is illegal; it is clamped to log2(WORD), i.e. 1 bpp.
- Reset mid-operation drops all in-flight pixels; no partial write is issued.
- busy = s1_valid | s2_valid | out_valid.

Optional Feature:
- Macro: CANV_DRAW_AGU_TRANS_EN.
- Defined: in S1, a request with in_colr == trans_colr is treated exactly like a clipped pixel (accepted, dropped).
- Undefined: trans_colr is ignored; every in-canvas pixel is written.

Decomposition:
- Shared package gfx_pkg holds:
  - canvas config field widths (CORDW, ADDRW, SHIFTW defaults)
  - the packed coordinate layout {y, x} used by win_start/scale
  - the pixel-order constant (LSB-first)
- One sub-module: canv_pix_place (combinational). Maps colour, pix_id and addr_shift to out_data and out_mask; reusable by the blitter.

Test Plan:
- Base write: WORD=32, addr_base=0x100, shift=2 (8 bpp), canv_w=320, canv_h=240, (x=5, y=2, colr=0xAB).
  -> lin=645; 3 cycles later out_addr=0x100+161=0x1A1, pix_id=1, out_data=0x0000AB00, out_mask=0x0000FF00.
- 1 bpp packing: shift=5, (x=33, y=0, colr=0xFF).
  -> out_addr=base+1, pix_id=1, out_data=0x00000002, out_mask=0x00000002.
- Clipping: requests (-1,0), (320,0), (0,240), (319,239).
  -> all four accepted; only (319,239) emerges, at lin=76799.
- Backpressure: 8-pixel burst, out_ready low for 5 cycles mid-burst.
  -> out_* held stable while stalled; in_ready low; all 8 writes delivered in order, no duplicates.
- Async reset: rst_sys_n asserted with 3 pixels in flight.
  -> out_valid=0 and busy=0 immediately; after release the next pixel appears after 3 cycles with correct address.
- CANV_DRAW_AGU_TRANS_EN: trans_colr=0x00, pixels colr 0x00 then 0x11.
  -> only the 0x11 pixel written with macro defined; both written without it.
